// File: rtl/lift_req_queue.sv
// Lift hall-call request queue: circular FIFO of 3-bit button codes.
// Each code can be stored at most once. A rejected request raises a one-cycle dropped pulse.
module lift_req_queue #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_valid,
    input  logic [2:0] btn_code,
    input  logic       pop,
    output logic [2:0] req_out,
    output logic       q_empty,
    output logic       q_full,
    output logic [4:0] count,
    output logic       dropped
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lift_req_queue: DEPTH must be a power of two in 2..16");
    end

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [5:0]    pending;
    logic [5:0]    pend_after_pop;
    logic [5:0]    pending_nxt;
    logic [5:0]    code_bit;
    logic [5:0]    head_bit;
    logic [2:0]    head;
    logic          pop_ok;
    logic          push_ok;

    // Pending-mask bit for each legal code; 000 and 101 map to no bit.
    function automatic logic [5:0] code_onehot(input logic [2:0] c);
        logic [5:0] b;
        case (c)
            3'b001:  b = 6'b000001;
            3'b010:  b = 6'b000010;
            3'b011:  b = 6'b000100;
            3'b100:  b = 6'b001000;
            3'b110:  b = 6'b010000;
            3'b111:  b = 6'b100000;
            default: b = 6'b000000;
        endcase
        return b;
    endfunction

    // The duplicate check sees the mask with the popped code already cleared.
    // This lets the head code be requested again in the cycle it leaves.
    always_comb begin
        head           = mem[rd_ptr];
        pop_ok         = pop && (count != '0);
        code_bit       = code_onehot(btn_code);
        head_bit       = code_onehot(head);
        pend_after_pop = pop_ok ? (pending & ~head_bit) : pending;
        push_ok        = btn_valid && (code_bit != '0)
                         && ((pend_after_pop & code_bit) == '0)
                         && ((count != DEPTH_C) || pop_ok);
        pending_nxt    = push_ok ? (pend_after_pop | code_bit) : pend_after_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            dropped <= btn_valid && !push_ok;
            pending <= pending_nxt;
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // When full, the write slot equals the slot being read. The head moves past it on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem[wr_ptr] <= btn_code;
    end

    assign q_empty = (count == '0);
    assign q_full  = (count == DEPTH_C);
    assign req_out = q_empty ? 3'b000 : head;

endmodule

// File: tb/tb_lift_req_queue.sv
// Bench for lift_req_queue: DEPTH=8 and DEPTH=4 instances receive the same stimulus.
// Each instance is checked every cycle against a list-based reference model.
module tb_lift_req_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_valid;
    logic [2:0] btn_code;
    logic       pop;

    logic [2:0] req_out8, req_out4;
    logic       q_empty8, q_empty4, q_full8, q_full4, dropped8, dropped4;
    logic [4:0] count8, count4;

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 is DEPTH=8, index 1 is DEPTH=4. Entries are kept head-first.
    int         mdepth [2] = '{8, 4};
    int         mcnt   [2];
    logic [2:0] mbuf   [2][8];
    bit         mdrop  [2];

    always #5 clk = ~clk;

    lift_req_queue #(.DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .btn_valid(btn_valid), .btn_code(btn_code), .pop(pop),
        .req_out(req_out8), .q_empty(q_empty8), .q_full(q_full8), .count(count8),
        .dropped(dropped8)
    );

    lift_req_queue #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .btn_valid(btn_valid), .btn_code(btn_code), .pop(pop),
        .req_out(req_out4), .q_empty(q_empty4), .q_full(q_full4), .count(count4),
        .dropped(dropped4)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit v, input logic [2:0] c,
                              input bit p);
        bit popped, dup, accept;
        int first;
        if (rst) begin
            mcnt[i]  = 0;
            mdrop[i] = 0;
            return;
        end
        popped = p && (mcnt[i] > 0);
        first  = popped ? 1 : 0;
        dup    = 0;
        for (int j = first; j < mcnt[i]; j++)
            if (mbuf[i][j] == c) dup = 1;
        accept = v && (c != 3'd0) && (c != 3'd5) && !dup
                 && ((mcnt[i] < mdepth[i]) || popped);
        mdrop[i] = v && !accept;
        if (popped) begin
            for (int j = 0; j < 7; j++) mbuf[i][j] = mbuf[i][j+1];
            mcnt[i]--;
        end
        if (accept) begin
            mbuf[i][mcnt[i]] = c;
            mcnt[i]++;
        end
    endtask

    task automatic check_all();
        int er;
        er = (mcnt[0] > 0) ? int'(mbuf[0][0]) : 0;
        check("d8.count",   int'(count8),   mcnt[0]);
        check("d8.req_out", int'(req_out8), er);
        check("d8.q_empty", int'(q_empty8), int'(mcnt[0] == 0));
        check("d8.q_full",  int'(q_full8),  int'(mcnt[0] == mdepth[0]));
        check("d8.dropped", int'(dropped8), int'(mdrop[0]));
        er = (mcnt[1] > 0) ? int'(mbuf[1][0]) : 0;
        check("d4.count",   int'(count4),   mcnt[1]);
        check("d4.req_out", int'(req_out4), er);
        check("d4.q_empty", int'(q_empty4), int'(mcnt[1] == 0));
        check("d4.q_full",  int'(q_full4),  int'(mcnt[1] == mdepth[1]));
        check("d4.dropped", int'(dropped4), int'(mdrop[1]));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next edge.
    task automatic cycle(input bit rst, input bit v, input logic [2:0] c, input bit p);
        rst_n     = !rst;
        btn_valid = v;
        btn_code  = c;
        pop       = p;
        @(posedge clk);
        #1;
        model_step(0, rst, v, c, p);
        model_step(1, rst, v, c, p);
        check_all();
    endtask

    task automatic push(input logic [2:0] c);
        cycle(0, 1, c, 0);
    endtask

    task automatic do_pop();
        cycle(0, 0, 3'd0, 1);
    endtask

    initial begin
        rst_n = 0; btn_valid = 0; btn_code = '0; pop = 0;
        mcnt = '{0, 0}; mdrop = '{0, 0};
        cycle(1, 1, 3'd3, 1);
        cycle(1, 0, 3'd0, 0);
        check("reset.count", int'(count4), 0);
        check("reset.q_empty", int'(q_empty8), 1);
        check("reset.req_out", int'(req_out8), 0);

        // Arrival order and draining to empty
        push(3'b011); push(3'b110); push(3'b001);
        check("order.count3", int'(count8), 3);
        check("order.head", int'(req_out4), 3);
        do_pop(); check("order.pop1", int'(req_out8), 6);
        do_pop(); check("order.pop2", int'(req_out8), 1);
        do_pop(); check("order.empty", int'(q_empty8), 1);

        // Duplicate and invalid codes
        push(3'b010); push(3'b010);
        check("dup.dropped", int'(dropped4), 1);
        check("dup.count", int'(count4), 1);
        cycle(0, 0, 3'd0, 0);
        check("dup.pulse_one_cycle", int'(dropped4), 0);
        push(3'b000); check("inv0.dropped", int'(dropped8), 1);
        push(3'b101); check("inv5.dropped", int'(dropped8), 1);
        do_pop();

        // Full behaviour on DEPTH=4
        push(3'b001); push(3'b010); push(3'b011); push(3'b100);
        check("full.q_full4", int'(q_full4), 1);
        check("full.q_full8", int'(q_full8), 0);
        push(3'b110); check("full.dropped4", int'(dropped4), 1);
        cycle(0, 1, 3'b110, 1);
        check("full.pushpop_count4", int'(count4), 4);
        check("full.pushpop_head4", int'(req_out4), 2);
        cycle(1, 0, 3'd0, 0);

        // Re-request of the code being popped
        push(3'b111);
        cycle(0, 1, 3'b111, 1);
        check("repush.count", int'(count8), 1);
        check("repush.head", int'(req_out8), 7);
        do_pop(); do_pop();
        check("underflow.count", int'(count4), 0);

        // Random traffic with pointer wrap and occasional reset
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
        end

        // Reset with entries stored discards them and clears the pending mask
        cycle(1, 0, 3'd0, 0);
        push(3'b010); push(3'b011); push(3'b001);
        cycle(1, 0, 3'd0, 0);
        check("rst.count", int'(count4), 0);
        check("rst.q_empty", int'(q_empty4), 1);
        push(3'b010);
        check("rst.mask_clear", int'(dropped4), 0);
        check("rst.reaccept", int'(count4), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lift_req_queue.md
LIFT_REQ_QUEUE -- requirements
Module: lift_req_queue

Interface
REQ-001 Parameter DEPTH, default 8, meaning queue capacity in entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 btn_valid  input  1  request strobe; btn_code is sampled on each clk edge where btn_valid=1.
REQ-005 btn_code  input  3  request code: 001=1U, 010=2U, 011=3U, 110=2D, 111=3D, 100=4D; 000 and 101 are invalid.
REQ-006 pop  input  1  consumer acceptance strobe; high for one cycle when the lift controller takes the head entry.
REQ-007 req_out  output  3  head entry; 000 when empty; drives the lift controller request input.
REQ-008 q_empty  output  1  high when the entry count is 0; drives the lift controller empty input.
REQ-009 q_full  output  1  high when the entry count equals DEPTH.
REQ-010 count  output  5  number of stored entries, 0..DEPTH.
REQ-011 dropped  output  1  registered one-cycle pulse flagging a rejected request.

Function
REQ-012 Storage SHALL be a circular FIFO: DEPTH x 3-bit array, read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-013 A pending mask of 6 bits, one per valid code, SHALL be set on push and cleared on pop of that code.
REQ-014 Push acceptance: btn_valid=1, code valid, pending bit clear, and (count<DEPTH or the same cycle pops); all four SHALL hold.
REQ-015 Rejection causes (invalid code, duplicate pending, full without pop) SHALL assert dropped on the next cycle only; a rejected request SHALL NOT change FIFO state.
REQ-016 Pop takes effect when pop=1 and count>0; pop with count=0 SHALL be ignored with no underflow and no pointer change.
REQ-017 Simultaneous accepted push and valid pop: count unchanged, both pointers advance, write and read SHALL NOT collide in a way that corrupts the head.
REQ-018 Duplicate check in a push+pop cycle SHALL use the mask after clearing the popped code, so re-requesting the code being popped is accepted.
REQ-019 req_out SHALL equal mem[rd_ptr] combinationally from registered state when count>0, else 000; no internal combinational path from inputs to outputs.
REQ-020 Latency: a push into an empty queue at edge N SHALL show on req_out with q_empty=0 immediately after edge N.
REQ-021 Order: accepted requests SHALL leave in arrival order; no reordering or merging beyond REQ-018.
REQ-022 q_empty, q_full and count SHALL derive from one registered count register and stay mutually consistent every cycle.
REQ-023 Each code occupies at most one entry, so occupancy cannot exceed 6 even when DEPTH=8; q_full is reachable only when DEPTH<=4, otherwise it stays 0.

Reset
REQ-024 rst_n=0 at a clk edge SHALL clear pointers, count, pending mask and dropped, overriding any same-cycle push or pop.
REQ-025 Outputs after reset: req_out=000, q_empty=1, q_full=0, count=0, dropped=0.
REQ-026 Reset during operation SHALL discard all entries; array contents need not be cleared.

Verification
REQ-027 Reset, then push 011, 110, 001 on three cycles -> count=3; req_out=011; pops return 011, 110, 001; then q_empty=1, req_out=000.
REQ-028 Push 010 twice while pending -> second push gives dropped=1 for one cycle, count=1; push 000 and 101 -> dropped each time, count unchanged.
REQ-029 DEPTH=4, fill with 001, 010, 011, 100 -> q_full=1; push 110 -> dropped; push 110 with pop in the same cycle -> accepted, count=4, head=010.
REQ-030 Queue holding only 111: pop and push 111 in the same cycle -> accepted, count=1, req_out=111; pop with count=0 -> count stays 0.
REQ-031 DEPTH=4, run more than 12 push/pop cycles to force pointer wrap -> output order matches a reference model; rst_n=0 with 3 entries -> next cycle count=0, q_empty=1, mask clear (010 accepted again).
